// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage_if
// Brief    : Handshake/payload bundle for one pipe_skid_stage boundary.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_data_o;
    logic [1:0]       count_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // The stage itself.
    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o, stall_cnt_o
    );

    // The surrounding pipeline (upstream producer plus downstream consumer).
    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Stage register with valid/ready, 2-entry skid, flush, stall count.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 8,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic                clk,
    input  logic                rst,
    pipe_skid_stage_if.slave    bus
);
    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_state_nxt;
    logic       w_main_from_in;
    logic       w_main_from_skid;
    logic       w_skid_from_in;

    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state == ST_BUSY) || (r_state == ST_FULL);
    assign w_push      = bus.in_valid_i && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = ST_BUSY;
                    w_main_from_in = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_push && w_pop) begin
                    w_main_from_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt    = ST_FULL;
                    w_skid_from_in = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ST_BUSY;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (bus.flush_i) begin
            r_state <= ST_EMPTY;
            if (ZERO_ON_FLUSH != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_main_from_in) begin
                r_main_data <= bus.in_data_i;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_skid_from_in) begin
                r_skid_data <= bus.in_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.flush_i || w_pop) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = r_main_data;
    assign bus.count_o     = r_state;
    assign bus.stall_cnt_o = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Directed-vector self-checking bench for pipe_skid_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;
    localparam int W = 16;

    logic clk;
    logic rst;

    typedef struct {
        logic          flush;
        logic          in_valid;
        logic          out_ready;
        logic [W-1:0]  data;
        logic          exp_valid;
        logic          exp_ready;
        logic [W-1:0]  exp_data;
        logic [1:0]    exp_count;
        logic [2:0]    exp_stall;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    pipe_skid_stage_if #(.WIDTH(W), .CNT_W(3)) bus0 ();
    pipe_skid_stage_if #(.WIDTH(W), .CNT_W(8)) bus1 ();

    pipe_skid_stage #(.WIDTH(W), .CNT_W(3), .ZERO_ON_FLUSH(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipe_skid_stage #(.WIDTH(W), .CNT_W(8), .ZERO_ON_FLUSH(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic fl, input logic iv, input logic ordy, input logic [W-1:0] d,
                       input logic ev, input logic er, input logic [W-1:0] ed,
                       input logic [1:0] ec, input logic [2:0] es);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.out_ready = ordy; v.data = d;
        v.exp_valid = ev; v.exp_ready = er; v.exp_data = ed; v.exp_count = ec; v.exp_stall = es;
        vecs.push_back(v);
    endtask

    task automatic check_bus0(input string tag, input logic ev, input logic er,
                              input logic [W-1:0] ed, input logic [1:0] ec, input logic [2:0] es);
        check({tag, ".valid"}, {31'd0, bus0.out_valid_o}, {31'd0, ev});
        check({tag, ".ready"}, {31'd0, bus0.in_ready_o},  {31'd0, er});
        check({tag, ".data"},  {16'd0, bus0.out_data_o},  {16'd0, ed});
        check({tag, ".count"}, {30'd0, bus0.count_o},     {30'd0, ec});
        check({tag, ".stall"}, {29'd0, bus0.stall_cnt_o}, {29'd0, es});
    endtask

    initial begin
        // Each vector: inputs driven for one cycle, expectations sampled after the edge.
        // Stream with out_ready high.
        add(0, 1, 1, 16'h0011, 1, 1, 16'h0011, 2'd1, 3'd0);
        add(0, 1, 1, 16'h0022, 1, 1, 16'h0022, 2'd1, 3'd0);
        add(0, 1, 1, 16'h0033, 1, 1, 16'h0033, 2'd1, 3'd0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h0033, 2'd0, 3'd0);
        // Backpressure into the skid, blocked push, then ordered drain.
        add(0, 1, 0, 16'h00A0, 1, 1, 16'h00A0, 2'd1, 3'd0);
        add(0, 1, 0, 16'h00A1, 1, 0, 16'h00A0, 2'd2, 3'd1);
        add(0, 1, 0, 16'h00A2, 1, 0, 16'h00A0, 2'd2, 3'd2);
        add(0, 1, 1, 16'h00A2, 1, 1, 16'h00A1, 2'd1, 3'd0);
        add(0, 1, 1, 16'h00A2, 1, 1, 16'h00A2, 2'd1, 3'd0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h00A2, 2'd0, 3'd0);
        // Flush while FULL with a simultaneous push of 0xFF.
        add(0, 1, 0, 16'h00B0, 1, 1, 16'h00B0, 2'd1, 3'd0);
        add(0, 1, 0, 16'h00B1, 1, 0, 16'h00B0, 2'd2, 3'd1);
        add(1, 1, 0, 16'h00FF, 0, 1, 16'h0000, 2'd0, 3'd0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h0000, 2'd0, 3'd0);
        // Stall counter saturation at 7 with CNT_W=3, then cleared by a pop.
        add(0, 1, 0, 16'h00C0, 1, 1, 16'h00C0, 2'd1, 3'd0);
        for (int k = 1; k <= 10; k++)
            add(0, 0, 0, 16'h0000, 1, 1, 16'h00C0, 2'd1, (k > 7) ? 3'd7 : 3'(k));
        add(0, 0, 1, 16'h0000, 0, 1, 16'h00C0, 2'd0, 3'd0);

        rst = 1'b1;
        bus0.flush_i = 1'b0; bus0.in_valid_i = 1'b0; bus0.in_data_i = 'x; bus0.out_ready_i = 1'b0;
        bus1.flush_i = 1'b0; bus1.in_valid_i = 1'b0; bus1.in_data_i = 'x; bus1.out_ready_i = 1'b0;
        #3;
        check_bus0("reset", 1'b0, 1'b1, 16'h0000, 2'd0, 3'd0);
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus0.flush_i     = vecs[i].flush;
            bus0.in_valid_i  = vecs[i].in_valid;
            bus0.out_ready_i = vecs[i].out_ready;
            bus0.in_data_i   = vecs[i].in_valid ? vecs[i].data : 'x;
            tick();
            check_bus0($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready,
                       vecs[i].exp_data, vecs[i].exp_count, vecs[i].exp_stall);
        end

        // Asynchronous reset while FULL, asserted between clock edges.
        bus0.flush_i = 1'b0; bus0.out_ready_i = 1'b0;
        bus0.in_valid_i = 1'b1; bus0.in_data_i = 16'h00D0;
        tick();
        bus0.in_data_i = 16'h00D1;
        tick();
        bus0.in_valid_i = 1'b0; bus0.in_data_i = 'x;
        check("arst.pre_count", {30'd0, bus0.count_o}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_bus0("arst", 1'b0, 1'b1, 16'h0000, 2'd0, 3'd0);
        #1;
        rst = 1'b0;
        bus0.in_valid_i = 1'b1; bus0.in_data_i = 16'h0005; bus0.out_ready_i = 1'b1;
        tick();
        bus0.in_valid_i = 1'b0; bus0.in_data_i = 'x;
        check_bus0("arst.push", 1'b1, 1'b1, 16'h0005, 2'd1, 3'd0);

        // Flush without zeroing keeps the payload but drops valid.
        bus1.in_valid_i = 1'b1; bus1.in_data_i = 16'h1234; bus1.out_ready_i = 1'b0;
        tick();
        bus1.in_valid_i = 1'b0; bus1.in_data_i = 'x;
        check("nz.load_valid", {31'd0, bus1.out_valid_o}, 32'd1);
        check("nz.load_data",  {16'd0, bus1.out_data_o},  32'h1234);
        bus1.flush_i = 1'b1;
        tick();
        bus1.flush_i = 1'b0;
        check("nz.flush_valid", {31'd0, bus1.out_valid_o}, 32'd0);
        check("nz.flush_data",  {16'd0, bus1.out_data_o},  32'h1234);
        check("nz.flush_ready", {31'd0, bus1.in_ready_o},  32'd1);
        check("nz.flush_count", {30'd0, bus1.count_o},     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed, always-advancing pipeline registers (if_id, id_ex, ex_mem, mem_wb) between the core's stages.
- Provides a WIDTH-bit stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush that inserts a bubble, and a saturating stall-cycle counter.
- Lets any stage stall or flush without a combinational ready path back through the pipeline.
- Instantiated once per stage boundary in the next-generation core top.

Parameters:
- WIDTH, 32, payload width in bits (packed stage bundle, e.g. pc+inst = 64).
- CNT_W, 8, width of stall-cycle counter.
- ZERO_ON_FLUSH, 1, 1 = payload registers cleared to 0 on flush (all-zero = NOP bubble); 0 = payload retained, only valid flags cleared.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush, drops all held entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept; driven only by registered state.
- in_data_i  in  WIDTH  upstream payload.
- out_valid_o  out  1  payload at output valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  WIDTH  output payload (main register).
- count_o  out  2  occupancy: 0, 1 or 2.
- stall_cnt_o  out  CNT_W  consecutive cycles out_valid_o=1 && out_ready_i=0, saturating.

Behaviour:
- Single clock. Reset is asynchronous and active-high on rst; ports named clk and rst.
- Reset values: main/skid valid=0, out_data_o=0, skid data=0, count_o=0, stall_cnt_o=0, out_valid_o=0, in_ready_o=1.
- push = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
- in_ready_o = !skid_valid. out_valid_o = main_valid. out_data_o = main_data.
- States and transitions (evaluated at posedge clk when flush_i=0):
  - EMPTY, count 0:
    - push -> BUSY, main<=in_data_i.
    - else stay.
  - BUSY, count 1:
    - push&&pop -> BUSY, main<=in_data_i.
    - push&&!pop -> FULL, skid<=in_data_i, main unchanged.
    - !push&&pop -> EMPTY.
    - else hold.
  - FULL, count 2 (in_ready_o=0, so no push):
    - pop -> BUSY, main<=skid, skid_valid<=0.
    - else hold.
- Latency: data accepted on cycle N appears on out_data_o with out_valid_o=1 in cycle N+1.
- Throughput: 1 transfer/cycle sustained while out_ready_i=1.
- Order preserved: the skid entry is always older than any later push and is emitted before it.
- flush_i=1 has priority over everything:
  - next state is EMPTY, count 0, regardless of push/pop.
  - A push in the flush cycle is discarded; a pop in the flush cycle still counts as taken by downstream.
  - ZERO_ON_FLUSH=1: main and skid data <=0. ZERO_ON_FLUSH=0: data unchanged.
  - in_ready_o=1 and out_valid_o=0 from the next cycle.
- Stall counter:
  - out_valid_o && !out_ready_i: stall_cnt_o <= stall_cnt_o+1, saturating at 2^CNT_W-1 (no wrap).
  - Cleared to 0 on pop or flush.
  - Held otherwise, including while EMPTY.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); held entries are lost.
- Release of rst: first push is accepted on the first posedge after deassertion.
- No combinational path from out_ready_i or in_valid_i to in_ready_o or out_valid_o.
- X on in_data_i when in_valid_i=0 must not propagate to state.

Test Plan:
1. Reset then stream: out_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data_o 0x11,0x22,0x33 on following cycles, out_valid_o=1 each cycle, count_o=1, in_ready_o stays 1.
2. Backpressure/skid: push 0xA0, hold out_ready_i=0, push 0xA1 -> count_o=2, in_ready_o=0; in_valid_i=1 with 0xA2 held is not accepted. Raise out_ready_i -> outputs 0xA0, 0xA1, then 0xA2 in order with no loss or duplication.
3. Flush while FULL with simultaneous push of 0xFF (ZERO_ON_FLUSH=1) -> next cycle count_o=0, out_valid_o=0, out_data_o=0, in_ready_o=1; 0xFF never appears at the output.
4. Stall counter, CNT_W=3: hold out_valid_o=1, out_ready_i=0 for 10 cycles -> stall_cnt_o 1..7 then stays 7. One pop -> 0.
5. Async reset mid-FULL: assert rst between clock edges -> out_valid_o=0, in_ready_o=1, count_o=0 before the next edge. Deassert and push 0x5 -> appears one cycle later.
6. ZERO_ON_FLUSH=0: main holds 0x1234, assert flush_i -> out_valid_o=0, out_data_o stays 0x1234.
